// File: rtl/sym_vn_lut_loader_pkg.sv
// Shared sizing and FSM encoding for the symmetric VN LUT write-side loader.
package sym_vn_lut_loader_pkg;

  localparam int unsigned QUAN_SIZE   = 4;
  localparam int unsigned PAGE_ADDR_W = 6;
  localparam int unsigned PAGE_NUM    = 64;
  localparam int unsigned CNT_W       = PAGE_ADDR_W + 1;

  // Index of the final entry of a table: 2*PAGE_NUM-1.
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(2 * PAGE_NUM - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StFin  = 2'd2
  } state_e;

endpackage

// File: rtl/sym_vn_lut_loader.sv
// Packs a serial stream of quantised LUT entries into even/odd bank pairs and issues one
// registered page write per pair into a selectable offset half, tracking complete tables.
module sym_vn_lut_loader
  import sym_vn_lut_loader_pkg::*;
(
  input  logic                   write_clk_i,
  input  logic                   rst_ni,
  input  logic                   load_start_i,
  input  logic                   load_offset_i,
  input  logic                   load_abort_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [QUAN_SIZE-1:0]   in_data_i,
  output logic [QUAN_SIZE-1:0]   lut_in_bank0_o,
  output logic [QUAN_SIZE-1:0]   lut_in_bank1_o,
  output logic [PAGE_ADDR_W-1:0] page_write_addr_o,
  output logic                   write_addr_offset_o,
  output logic                   we_o,
  output logic                   busy_o,
  output logic                   load_done_o,
  output logic [1:0]             table_valid_o
);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [QUAN_SIZE-1:0]   stage_q;
  logic [QUAN_SIZE-1:0]   bank0_q;
  logic [QUAN_SIZE-1:0]   bank1_q;
  logic [PAGE_ADDR_W-1:0] addr_q;
  logic                   offset_q;
  logic                   we_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             valid_q;
  logic                   accept;

  assign in_ready_o = (state_q == StLoad);
  // Abort wins over a same-cycle accept, so a pending odd entry never reaches the write bus.
  assign accept     = in_valid_i & in_ready_o & ~load_abort_i;

  always_ff @(posedge write_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stage_q  <= '0;
      bank0_q  <= '0;
      bank1_q  <= '0;
      addr_q   <= '0;
      offset_q <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 2'b00;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start_i) begin
            state_q                <= StLoad;
            busy_q                 <= 1'b1;
            offset_q               <= load_offset_i;
            valid_q[load_offset_i] <= 1'b0;
            cnt_q                  <= '0;
          end
        end
        StLoad: begin
          if (load_abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!cnt_q[0]) begin
              stage_q <= in_data_i;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= cnt_q[CNT_W-1:1];
              bank0_q <= stage_q;
              bank1_q <= in_data_i;
            end
            if (cnt_q == LAST_K) begin
              state_q <= StFin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StFin: begin
          // Flag the half only once the final page write has been presented.
          state_q           <= StIdle;
          valid_q[offset_q] <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lut_in_bank0_o      = bank0_q;
  assign lut_in_bank1_o      = bank1_q;
  assign page_write_addr_o   = addr_q;
  assign write_addr_offset_o = offset_q;
  assign we_o                = we_q;
  assign busy_o              = busy_q;
  assign load_done_o         = done_q;
  assign table_valid_o       = valid_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Randomised bench for sym_vn_lut_loader against a pair-list reference model.
module tb_sym_vn_lut_loader;
  import sym_vn_lut_loader_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   load_start = 1'b0;
  logic                   load_offset = 1'b0;
  logic                   load_abort = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [QUAN_SIZE-1:0]   in_data = '0;
  logic [QUAN_SIZE-1:0]   bank0;
  logic [QUAN_SIZE-1:0]   bank1;
  logic [PAGE_ADDR_W-1:0] page_addr;
  logic                   wr_offset;
  logic                   we;
  logic                   busy;
  logic                   load_done;
  logic [1:0]             table_valid;

  sym_vn_lut_loader dut (
    .write_clk_i        (clk),
    .rst_ni             (rst_n),
    .load_start_i       (load_start),
    .load_offset_i      (load_offset),
    .load_abort_i       (load_abort),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_data_i          (in_data),
    .lut_in_bank0_o     (bank0),
    .lut_in_bank1_o     (bank1),
    .page_write_addr_o  (page_addr),
    .write_addr_offset_o(wr_offset),
    .we_o               (we),
    .busy_o             (busy),
    .load_done_o        (load_done),
    .table_valid_o      (table_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a table load is a list of entries; every completed pair is one write.
  typedef struct {
    int   cyc;
    logic off;
    int   page;
    int   b0;
    int   b1;
  } wr_t;

  wr_t      exp_q[$];
  int       wr_cnt = 0;
  int       ncyc = 0;
  logic [1:0] tv_m = 2'b00;
  bit       loading_m = 0;
  logic     off_m = 1'b0;
  int       k_m = 0;
  int       staged_m = 0;

  always @(negedge clk) begin
    wr_t e;
    if (we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", 32'(we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("we_cycle", ncyc, e.cyc);
        check_eq("wr_offset", 32'(wr_offset), 32'(e.off));
        check_eq("wr_page", 32'(page_addr), e.page);
        check_eq("wr_bank0", 32'(bank0), e.b0);
        check_eq("wr_bank1", 32'(bank1), e.b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    ncyc++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {11'd0, we, busy, load_done, table_valid, in_ready, wr_offset, page_addr,
                   bank0, bank1}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_start = 0; load_abort = 0; in_valid = 0;
    #2;
    check_all_zero("reset_outputs");
    loading_m = 0; tv_m = 2'b00; exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_load(input logic off);
    load_start = 1'b1;
    load_offset = off;
    if (!loading_m) begin
      loading_m = 1; off_m = off; tv_m[off] = 1'b0; k_m = 0;
    end
    tick();
    load_start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'(loading_m));
    check_eq("start_ready", 32'(in_ready), 32'(loading_m));
    check_eq("start_offset", 32'(wr_offset), 32'(off_m));
    check_eq("start_tvalid", 32'(table_valid), 32'(tv_m));
  endtask

  task automatic stream(input int gap_pct, input int abort_at, input int mid_start_at,
                        input int rst_at, input bit rand_data);
    int  budget;
    bit  last_acc;
    bit  aborted;
    budget = 2000;
    while (loading_m && budget > 0) begin
      budget--;
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data = rand_data ? QUAN_SIZE'($urandom) : QUAN_SIZE'(k_m % 16);
      load_abort = (k_m == abort_at);
      if (k_m == mid_start_at) begin
        load_start = 1'b1; load_offset = 1'b1; mid_start_at = -1;
      end
      if (k_m == rst_at) begin
        rst_n = 1'b0;
        #2;
        check_all_zero("midload_reset");
        loading_m = 0; tv_m = 2'b00; exp_q.delete();
        in_valid = 0; load_abort = 0; load_start = 0;
        tick();
        rst_n = 1'b1;
      end else begin
        last_acc = 0;
        aborted = 0;
        if (load_abort) begin
          loading_m = 0; aborted = 1;
        end else if (in_valid) begin
          if (k_m % 2 == 0) staged_m = int'(in_data);
          else exp_q.push_back('{ncyc + 1, off_m, k_m / 2, staged_m, int'(in_data)});
          if (k_m == 2 * PAGE_NUM - 1) last_acc = 1;
          k_m++;
        end
        tick();
        load_abort = 0; load_start = 0; in_valid = 0;
        if (loading_m && !last_acc) check_eq("hold_offset", 32'(wr_offset), 32'(off_m));
        if (aborted) begin
          check_eq("abort_busy", 32'(busy), 32'd0);
          check_eq("abort_ready", 32'(in_ready), 32'd0);
          check_eq("abort_done", 32'(load_done), 32'd0);
        end
        if (last_acc) begin
          check_eq("fin_done", 32'(load_done), 32'd1);
          check_eq("fin_busy", 32'(busy), 32'd0);
          check_eq("fin_ready", 32'(in_ready), 32'd0);
          tick();
          loading_m = 0;
          tv_m[off_m] = 1'b1;
          check_eq("post_fin_done", 32'(load_done), 32'd0);
          check_eq("post_fin_tvalid", 32'(table_valid), 32'(tv_m));
        end
      end
    end
    check_eq("stream_finished", 32'(loading_m), 32'd0);
    tick(); tick();
    check_eq("writes_drained", exp_q.size(), 32'd0);
    check_eq("idle_tvalid", 32'(table_valid), 32'(tv_m));
    check_eq("idle_done", 32'(load_done), 32'd0);
  endtask

  initial begin
    #3;
    do_reset();

    // Full load, no gaps, offset 0.
    wr_cnt = 0;
    start_load(1'b0);
    stream(0, -1, -1, -1, 0);
    check_eq("t1_writes", wr_cnt, 32'd64);
    check_eq("t1_tvalid", 32'(table_valid), 32'd1);

    // Random gaps, offset 1, after a fresh reset.
    do_reset();
    wr_cnt = 0;
    start_load(1'b1);
    stream(40, -1, -1, -1, 0);
    check_eq("t2_writes", wr_cnt, 32'd64);
    check_eq("t2_tvalid", 32'(table_valid), 32'd2);

    // Abort after 37 accepts; the odd entry in the abort cycle is dropped.
    wr_cnt = 0;
    start_load(1'b0);
    stream(30, 37, -1, -1, 1);
    check_eq("t3_writes", wr_cnt, 32'd18);
    check_eq("t3_tvalid", 32'(table_valid), 32'd2);

    // Abort in idle does nothing.
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 32'd0);

    // Mid-load start with offset 1 is ignored.
    wr_cnt = 0;
    start_load(1'b0);
    stream(0, -1, 20, -1, 0);
    check_eq("t4_writes", wr_cnt, 32'd64);
    check_eq("t4_offset", 32'(wr_offset), 32'd0);

    // Reset at entry 50, then a normal load.
    start_load(1'b0);
    stream(0, -1, -1, 50, 0);
    wr_cnt = 0;
    start_load(1'b0);
    stream(20, -1, -1, -1, 1);
    check_eq("t5_writes", wr_cnt, 32'd64);

    // Offset 0, 1, then 0 again.
    do_reset();
    start_load(1'b0);
    stream(10, -1, -1, -1, 1);
    check_eq("t6_tv_a", 32'(table_valid), 32'd1);
    start_load(1'b1);
    stream(10, -1, -1, -1, 1);
    check_eq("t6_tv_b", 32'(table_valid), 32'd3);
    start_load(1'b0);
    check_eq("t6_tv_c", 32'(table_valid), 32'd2);
    stream(10, -1, -1, -1, 1);
    check_eq("t6_tv_d", 32'(table_valid), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
